// File: rtl/jtkicker_arb_pkg.sv
// Shared types and constants for the kicker-family SDRAM ROM arbiter.
package jtkicker_arb_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;

    // Slot visited on step k of a round-robin search that starts after 'last'.
    function automatic int rr_index(input int last, input int k, input int sw);
        return (last + k) % sw;
    endfunction

endpackage

// File: rtl/jtkicker_sdram_arb_if.sv
// SDRAM read-port handshake between the ROM arbiter and the SDRAM controller.
interface jtkicker_sdram_arb_if #(
    parameter int AW = 22
) ();
    import jtkicker_arb_pkg::*;

    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [DW-1:0] data_read;

    modport master (
        output sdram_req, sdram_addr,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr,
        output sdram_ack, data_rdy, data_read
    );

endinterface

// File: rtl/jtkicker_arb_slot.sv
// One-word read cache for a single ROM requester: address/data/valid plus hit logic.
module jtkicker_arb_slot
    import jtkicker_arb_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic          flush,      // held high for the whole ROM download
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          miss,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] caddr_q, caddr_d;
    logic [DW-1:0] cdata_q, cdata_d;
    logic          cval_q,  cval_d;
    logic          hit;

    // NOTE: next-state logic uses blocking assignments and starts from the
    // held value, so every path assigns every _d signal and no latch appears.
    always_comb begin
        caddr_d = caddr_q;
        cdata_d = cdata_q;
        cval_d  = cval_q;
        if (flush) begin
            cval_d = 1'b0;
        end else if (fill) begin
            caddr_d = fill_addr;
            cdata_d = fill_data;
            cval_d  = 1'b1;
        end
    end

    // NOTE: the cached word is a small flop bank, not a RAM, so it is reset
    // to zero; sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            caddr_q <= '0;
            cdata_q <= '0;
            cval_q  <= 1'b0;
        end else begin
            caddr_q <= caddr_d;
            cdata_q <= cdata_d;
            cval_q  <= cval_d;
        end
    end

    assign hit  = cval_q && (addr == caddr_q);
    assign miss = cs && !hit;
    assign ok   = cs && hit && !flush;
    assign dout = cdata_q;

endmodule

// File: rtl/jtkicker_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SW cached ROM requesters.
module jtkicker_sdram_arb
    import jtkicker_arb_pkg::*;
#(
    parameter int SW = 4,
    parameter int AW = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 downloading,
    input  logic [SW-1:0]        slot_cs,
    input  logic [SW*AW-1:0]     slot_addr,
    output logic [SW*DW-1:0]     slot_dout,
    output logic [SW-1:0]        slot_ok,
    jtkicker_sdram_arb_if.master sdram
);

    localparam int GW = (SW > 1) ? $clog2(SW) : 1;

    arb_state_e    state_q, state_d;
    logic          req_q,   req_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [GW-1:0] gnt_q,   gnt_d;
    logic [GW-1:0] last_q,  last_d;

    logic [SW-1:0] miss;
    logic          fill_en;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] cand;

    for (genvar i = 0; i < SW; i++) begin : g_slot
        jtkicker_arb_slot #(.AW(AW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .cs        (slot_cs[i]),
            .addr      (slot_addr[i*AW +: AW]),
            .fill      (fill_en && (gnt_q == GW'(i))),
            .flush     (downloading),
            .fill_addr (addr_q),
            .fill_data (sdram.data_read),
            .miss      (miss[i]),
            .ok        (slot_ok[i]),
            .dout      (slot_dout[i*DW +: DW])
        );
    end

    // First missing slot strictly after the last grant, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= SW; k++) begin
            cand = GW'(rr_index(int'(last_q), k, SW));
            if (!pick_found && miss[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        fill_en = 1'b0;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (pick_found) begin
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = slot_addr[int'(pick_idx)*AW +: AW];
                    req_d   = 1'b1;
                    state_d = REQ;
                end
                REQ: if (sdram.sdram_ack) begin
                    req_d = 1'b0;
                    // A data_rdy in the ack cycle completes the fill at once.
                    if (sdram.data_rdy) begin
                        fill_en = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT: if (sdram.data_rdy) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            gnt_q   <= '0;
            last_q  <= GW'(SW - 1);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign sdram.sdram_req  = req_q;
    assign sdram.sdram_addr = addr_q;

endmodule

// File: tb/tb_jtkicker_sdram_arb.sv
// Directed and randomized bench for jtkicker_sdram_arb against a cache/round-robin model.
module tb_jtkicker_sdram_arb;
    import jtkicker_arb_pkg::*;

    localparam int SW = 4;
    localparam int AW = 22;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              downloading = 1'b0;
    logic [SW-1:0]     cs;
    logic [AW-1:0]     a [SW];
    logic [SW*AW-1:0]  slot_addr;
    logic [SW*DW-1:0]  slot_dout;
    logic [SW-1:0]     slot_ok;

    int checks = 0;
    int errors = 0;

    // Reference model: one cached word per slot plus the last granted slot.
    logic [AW-1:0] m_caddr [SW];
    logic [DW-1:0] m_cdata [SW];
    logic          m_val   [SW];
    int            m_last;
    int            cur_slot;
    logic [AW-1:0] cur_addr;

    jtkicker_sdram_arb_if #(.AW(AW)) sd_if ();

    jtkicker_sdram_arb #(.SW(SW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .slot_cs     (cs),
        .slot_addr   (slot_addr),
        .slot_dout   (slot_dout),
        .slot_ok     (slot_ok),
        .sdram       (sd_if)
    );

    always #5 clk = ~clk;

    always_comb begin
        slot_addr = '0;
        for (int i = 0; i < SW; i++) slot_addr[i*AW +: AW] = a[i];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < SW; i++) begin
            m_caddr[i] = '0;
            m_cdata[i] = '0;
            m_val[i]   = 1'b0;
        end
        m_last = SW - 1;
    endtask

    function automatic int exp_pick();
        for (int k = 1; k <= SW; k++) begin
            int idx;
            idx = (m_last + k) % SW;
            if (cs[idx] && !(m_val[idx] && a[idx] == m_caddr[idx])) return idx;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [SW-1:0]    eok;
        logic [SW*DW-1:0] edout;
        for (int i = 0; i < SW; i++) begin
            eok[i] = cs[i] && m_val[i] && (a[i] == m_caddr[i]) && !downloading;
            edout[i*DW +: DW] = m_cdata[i];
        end
        check("slot_ok", 64'(slot_ok), 64'(eok));
        check("slot_dout", 64'(slot_dout), 64'(edout));
    endtask

    task automatic model_fill(input logic [DW-1:0] data);
        m_caddr[cur_slot] = cur_addr;
        m_cdata[cur_slot] = data;
        m_val[cur_slot]   = 1'b1;
    endtask

    // Miss present now (FSM idle): the request must be up after one edge.
    task automatic grant_check();
        int p;
        p = exp_pick();
        tick();
        check("req_rise", 64'(sd_if.sdram_req), 64'd1);
        if (p >= 0) begin
            cur_slot = p;
            cur_addr = a[p];
            m_last   = p;
        end
        check("req_addr", 64'(sd_if.sdram_addr), 64'(cur_addr));
    endtask

    task automatic ack_phase(input int n, input bit same, input logic [DW-1:0] data);
        repeat (n) tick();
        check("req_hold", 64'(sd_if.sdram_req), 64'd1);
        check("addr_hold", 64'(sd_if.sdram_addr), 64'(cur_addr));
        sd_if.sdram_ack = 1'b1;
        if (same) begin
            sd_if.data_rdy  = 1'b1;
            sd_if.data_read = data;
        end
        tick();
        sd_if.sdram_ack = 1'b0;
        sd_if.data_rdy  = 1'b0;
        check("req_drop", 64'(sd_if.sdram_req), 64'd0);
        if (same) model_fill(data);
        check_outputs();
    endtask

    task automatic rdy_phase(input int n, input logic [DW-1:0] data);
        repeat (n) tick();
        check("req_low_wait", 64'(sd_if.sdram_req), 64'd0);
        sd_if.data_rdy  = 1'b1;
        sd_if.data_read = data;
        tick();
        sd_if.data_rdy = 1'b0;
        model_fill(data);
        check_outputs();
    endtask

    task automatic serve_all();
        for (int n = 0; n <= SW && exp_pick() >= 0; n++) begin
            grant_check();
            ack_phase(0, 1'b1, 16'($urandom));
        end
    endtask

    initial begin
        cs = '0;
        for (int i = 0; i < SW; i++) a[i] = '0;
        sd_if.sdram_ack = 1'b0;
        sd_if.data_rdy  = 1'b0;
        sd_if.data_read = '0;
        model_reset();

        // Reset state.
        repeat (3) tick();
        check("rst_req", 64'(sd_if.sdram_req), 64'd0);
        check("rst_addr", 64'(sd_if.sdram_addr), 64'd0);
        check_outputs();
        rst_n = 1'b1;
        tick();

        // Single miss on slot 1, ack after 3 cycles, data 5 cycles later.
        cs   = 4'b0010;
        a[1] = 22'h1234;
        #1 check_outputs();
        grant_check();
        check("s1_addr", 64'(sd_if.sdram_addr), 64'h1234);
        ack_phase(3, 1'b0, '0);
        rdy_phase(5, 16'hBEEF);
        check("s1_ok", 64'(slot_ok[1]), 64'd1);
        check("s1_dout", 64'(slot_dout[31:16]), 64'hBEEF);
        repeat (3) begin
            tick();
            check("s1_no_rereq", 64'(sd_if.sdram_req), 64'd0);
        end
        a[1] = 22'h0999;
        #1 check("hit_lat_miss", 64'(slot_ok[1]), 64'd0);
        a[1] = 22'h1234;
        #1 check("hit_lat_hit", 64'(slot_ok[1]), 64'd1);

        // Slot 2 moves to another address while its fill is in flight.
        cs   = 4'b0110;
        a[2] = 22'h0010;
        grant_check();
        ack_phase(1, 1'b0, '0);
        a[2] = 22'h0020;
        rdy_phase(2, 16'hA5A5);
        check("chg_ok_low", 64'(slot_ok[2]), 64'd0);
        grant_check();
        check("chg_rereq", 64'(sd_if.sdram_addr), 64'h0020);
        ack_phase(0, 1'b0, '0);
        rdy_phase(1, 16'h5A5A);

        // Download raised while waiting for data.
        cs   = 4'b1110;
        a[3] = 22'h0777;
        grant_check();
        ack_phase(0, 1'b0, '0);
        downloading = 1'b1;
        #1 check("dl_ok_low", 64'(slot_ok), 64'd0);
        tick();
        for (int i = 0; i < SW; i++) m_val[i] = 1'b0;
        check("dl_req_low", 64'(sd_if.sdram_req), 64'd0);
        sd_if.data_rdy  = 1'b1;
        sd_if.data_read = 16'h5555;
        tick();
        sd_if.data_rdy = 1'b0;
        check_outputs();
        tick();
        check("dl_no_grant", 64'(sd_if.sdram_req), 64'd0);
        downloading = 1'b0;
        #1 check("dl_prev_hit_miss", 64'(slot_ok[1]), 64'd0);
        serve_all();

        // Ack and data in the same cycle; the next miss follows immediately.
        cs   = 4'b1001;
        a[0] = 22'h0055;
        a[3] = 22'h0066;
        grant_check();
        ack_phase(2, 1'b1, 16'h1111);
        grant_check();
        ack_phase(0, 1'b1, 16'h2222);

        // Async reset in REQ, then all four slots miss together.
        cs   = 4'b0010;
        a[1] = 22'h2222;
        grant_check();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_req", 64'(sd_if.sdram_req), 64'd0);
        check("arst_addr", 64'(sd_if.sdram_addr), 64'd0);
        check_outputs();
        cs = 4'b1111;
        for (int i = 0; i < SW; i++) a[i] = 22'h300 + AW'(i);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < SW; k++) begin
            grant_check();
            check("rr_order", 64'(sd_if.sdram_addr), 64'(22'h300 + AW'(k)));
            ack_phase(0, 1'b0, '0);
            rdy_phase(0, 16'(16'hC000 + k));
            if (k == 0) a[0] = 22'h03F0;
        end
        grant_check();
        check("rr_wrap", 64'(sd_if.sdram_addr), 64'h03F0);
        ack_phase(0, 1'b1, 16'h0F0F);

        // Randomized traffic over a small address set so hits recur.
        for (int it = 0; it < 60; it++) begin
            cs = SW'($urandom);
            for (int i = 0; i < SW; i++) begin
                case ($urandom_range(0, 3))
                    0: a[i] = 22'h000100;
                    1: a[i] = 22'h000101;
                    2: a[i] = 22'h00002A;
                    default: a[i] = 22'h3FFFFF;
                endcase
            end
            #1 check_outputs();
            if (exp_pick() >= 0) begin
                bit same;
                logic [DW-1:0] d;
                same = 1'($urandom_range(0, 1));
                d    = 16'($urandom);
                grant_check();
                ack_phase($urandom_range(0, 3), same, d);
                if (!same) rdy_phase($urandom_range(0, 3), d);
            end else begin
                tick();
                check("rand_idle", 64'(sd_if.sdram_req), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkicker_sdram_arb.md
# jtkicker_sdram_arb

Round-robin arbiter that shares the single SDRAM read port among up to four ROM fetch requesters (scroll, object, PCM, sound or main CPU) in the kicker-family game cores. Each requester presents a word address and a chip select and receives a 16-bit word plus an ok flag. The block keeps one cached word per requester, so repeated reads of the same address do not go to SDRAM. It sits between the game's ROM consumers and the SDRAM controller, and is idle while the ROM download is in progress.

## Interface
Parameters:
- SW, 4, number of requester slots (2..4)
- AW, 22, SDRAM word-address width

Ports:
- clk  in  1  system clock (48 MHz domain)
- rst_n  in  1  asynchronous reset, active low
- downloading  in  1  ROM download in progress; blocks all traffic
- slot_cs  in  SW  per-slot read request, level-sensitive
- slot_addr  in  SW*AW  per-slot word address; slot i occupies bits [i*AW +: AW]
- slot_dout  out  SW*16  per-slot cached word
- slot_ok  out  SW  slot_dout is valid for the current slot_addr
- sdram_req  out  1  read request to the SDRAM controller
- sdram_addr  out  AW  address of the request
- sdram_ack  in  1  controller accepted the request (one-cycle pulse)
- data_rdy  in  1  data_read is valid (one-cycle pulse)
- data_read  in  16  SDRAM read data

## Operation
- Per-slot state: cached address `caddr[i]`, cached data `cdata[i]`, valid bit `cval[i]`.
- Hit condition: `hit[i] = cval[i] & (slot_addr[i] == caddr[i])`.
- `slot_ok[i] = slot_cs[i] & hit[i] & ~downloading`. This output is combinational.
- `slot_dout[i] = cdata[i]`.
- Miss: `miss[i] = slot_cs[i] & ~hit[i]`.
- FSM states: IDLE, REQ, WAIT.
- IDLE: if any miss exists and downloading=0:
  - Grant the first missing slot searching upward from `last+1`, mod SW.
  - Register `gnt <= slot`, `last <= slot`, `sdram_addr <= slot_addr[slot]`, `sdram_req <= 1`.
  - Move to REQ.
- REQ: hold sdram_req and sdram_addr stable. On sdram_ack, set `sdram_req <= 0` and move to WAIT.
- WAIT: on data_rdy:
  - `cdata[gnt] <= data_read`, `caddr[gnt] <= sdram_addr`, `cval[gnt] <= 1`.
  - Move to IDLE.
- The requested address is always the one stored in the cache. If the slot has since moved to another address, it shows a miss and is re-arbitrated.
- A slot_cs drop mid-transaction does not abort the transaction; the fill still completes.
- downloading=1, in any state:
  - FSM returns to IDLE the next cycle.
  - `sdram_req <= 0`.
  - All cval are cleared.
  - data_rdy is ignored until downloading falls.
- Simultaneous sdram_ack and data_rdy while in REQ: treat as ack then fill. The FSM goes directly to IDLE with the cache written.

## Timing
- Reset values:
  - State IDLE, `sdram_req=0`, `sdram_addr=0`.
  - `gnt=0`, `last=SW-1`, so slot 0 wins the first tie.
  - All cval=0, caddr=0, cdata=0.
  - slot_ok=0, slot_dout=0.
- Hit latency is 0 cycles: slot_ok follows slot_addr combinationally.
- Miss latency:
  - Miss visible at edge N → sdram_req high after edge N+1.
  - sdram_req drops on the edge that samples sdram_ack.
  - slot_ok rises the cycle after the edge that samples data_rdy.
  - Total = 2 + (ack wait) + (rdy wait) cycles.
- One transaction is outstanding at a time; there is no pipelining.
- Round-robin guarantee: a continuously missing slot is granted within SW transactions.

## Structure
- Shared package jtkicker_arb_pkg:
  - State enum {IDLE, REQ, WAIT}.
  - Data width constant DW=16.
- Sub-module jtkicker_arb_slot, instantiated SW times:
  - Holds caddr/cdata/cval.
  - Produces hit, miss and ok.
  - Takes fill and flush strobes.
- The top level holds the FSM, the round-robin picker and the SDRAM registers.

## Test plan
- Single miss: slot1 cs=1, addr 22'h1234. Ack after 3 cycles, data_rdy after 5 more with data 16'hBEEF.
  - sdram_addr=22'h1234.
  - slot_ok[1]=1 with dout 16'hBEEF the cycle after data_rdy.
  - A re-read of 22'h1234 produces no new sdram_req.
- Round-robin: slots 0..3 all miss simultaneously, with immediate ack/rdy.
  - Grant order is 0,1,2,3.
  - A persistent new miss on slot 0 is next granted after slot 3.
- Address change in flight: slot2 requests 22'h0010, then switches to 22'h0020 before data_rdy.
  - The fill stores 22'h0010 and slot_ok[2] stays 0.
  - A second request goes out for 22'h0020.
- Download mid-WAIT: assert downloading during WAIT.
  - sdram_req=0 and all slot_ok=0.
  - A data_rdy pulse during download leaves the cache unchanged.
  - After downloading falls, a previous hit address now misses.
- Async reset mid-REQ: drive rst_n low between clock edges.
  - sdram_req drops immediately and all outputs take their reset values.
- Same-cycle ack+rdy in REQ:
  - The cache is filled and the FSM is IDLE on the next cycle.
  - The next miss is requested one cycle later.
